// File: rtl/frec_select_ctrl.sv
// frec_select_ctrl: debounces up/down buttons into a 3-bit frequency index and
// applies it to the DPWM only at a PWM period boundary.
module frec_select_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter bit WRAP       = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       boton_aumento,
  input  logic       boton_disminuye,
  input  logic       periodo_fin,
  output logic [2:0] numero_frec,
  output logic [2:0] frec_objetivo,
  output logic       pendiente,
  output logic       cambio_ok
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;
  logic [1:0]    raw, s1_q, s2_q, deb_q, deb_d, step_q, step_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic          up, dn;
  logic [2:0]    obj_q, obj_d, num_q, num_d;
  logic          pend_q, cok_q;
  state_t        state_q, state_d;
  assign raw = {boton_disminuye, boton_aumento};
  // index 0 = up, 1 = down; level flips only after DEB_CYCLES unbroken mismatch cycles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]  = (s2_q[i] == deb_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      deb_d[i]  = (s2_q[i] != deb_q[i] && cnt_q[i] == CNT_MAX) ? s2_q[i] : deb_q[i];
      step_d[i] = deb_d[i] & ~deb_q[i];
    end
  end
  assign up = step_q[0] & ~step_q[1] & enable;
  assign dn = step_q[1] & ~step_q[0] & enable;
  always_comb begin
    obj_d = up ? ((obj_q == 3'd7 && !WRAP) ? obj_q : obj_q + 3'd1)
          : dn ? ((obj_q == 3'd0 && !WRAP) ? obj_q : obj_q - 3'd1)
          : obj_q;
  end
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      IDLE:    state_d = (obj_d != num_q) ? PEND : IDLE;
      PEND:    state_d = (obj_d == num_q) ? IDLE : periodo_fin ? APPLY : PEND;
      APPLY: begin
        num_d   = obj_q;
        state_d = (obj_d != obj_q) ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '{default: '0};
      obj_q   <= '0;
      num_q   <= '0;
      pend_q  <= 1'b0;
      cok_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      obj_q   <= obj_d;
      num_q   <= num_d;
      pend_q  <= (state_d == PEND);
      cok_q   <= (state_q == APPLY);
      state_q <= state_d;
    end
  end
  assign numero_frec   = num_q;
  assign frec_objetivo = obj_q;
  assign pendiente     = pend_q;
  assign cambio_ok     = cok_q;
endmodule

// File: tb/tb_frec_select_ctrl.sv
// tb_frec_select_ctrl: scoreboard bench for the DPWM frequency selector controller.
module tb_frec_select_ctrl;
  localparam int DEB = 16;
  logic       clk = 1'b0, reset_n = 1'b0, en = 1'b0, b_up = 1'b0, b_dn = 1'b0, pfin = 1'b0;
  logic [2:0] num, obj, num_w, obj_w;
  logic       pend, cok, pend_w, cok_w;
  int         checks = 0, failures = 0;
  int         exp_obj_q[$], exp_num_q[$];
  int         m_obj = 0, m_num = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_obj = 3'd0;
  always #5 clk = ~clk;
  frec_select_ctrl #(.DEB_CYCLES(DEB), .WRAP(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(en), .boton_aumento(b_up), .boton_disminuye(b_dn),
    .periodo_fin(pfin), .numero_frec(num), .frec_objetivo(obj), .pendiente(pend), .cambio_ok(cok)
  );
  frec_select_ctrl #(.DEB_CYCLES(DEB), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(en), .boton_aumento(b_up), .boton_disminuye(b_dn),
    .periodo_fin(pfin), .numero_frec(num_w), .frec_objetivo(obj_w), .pendiente(pend_w), .cambio_ok(cok_w)
  );
  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  // every change of frec_objetivo and every cambio_ok must match a queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (obj != prev_obj) begin
        if (exp_obj_q.size() == 0) chk("obj_spurious", int'(obj), int'(prev_obj));
        else chk("obj_sb", int'(obj), exp_obj_q.pop_front());
      end
      if (cok) begin
        if (exp_num_q.size() == 0) chk("cok_spurious", 1, 0);
        else chk("num_sb", int'(num), exp_num_q.pop_front());
      end
    end
    prev_obj = obj;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input bit up, input bit dn, input int hold);
    int nv;
    if (hold > DEB && en && up != dn) begin
      nv = up ? (m_obj == 7 ? 7 : m_obj + 1) : (m_obj == 0 ? 0 : m_obj - 1);
      if (nv != m_obj) exp_obj_q.push_back(nv);
      m_obj = nv;
    end
    @(posedge clk); #1;
    b_up = up; b_dn = dn;
    cyc(hold);
    b_up = 1'b0; b_dn = 1'b0;
    cyc(DEB + 6);
  endtask
  task automatic bounce_press();
    @(posedge clk); #1;
    repeat (3) begin
      b_up = 1'b1; cyc(1);
      b_up = 1'b0; cyc(1);
    end
    press(1'b1, 1'b0, DEB + 5);
  endtask
  task automatic period_end(input string tag);
    int n;
    int exp_c;
    n = 0;
    exp_c = (m_obj != m_num) ? 1 : 0;
    if (exp_c == 1) begin
      exp_num_q.push_back(m_obj);
      m_num = m_obj;
    end
    @(posedge clk); #1 pfin = 1'b1;
    @(posedge clk); #1 pfin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cok) n++;
    end
    chk({tag, "_cok_width"}, n, exp_c);
  endtask
  initial begin
    #2;
    chk("rst_num", int'(num), 0);
    chk("rst_obj", int'(obj), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_cok", int'(cok), 0);
    cyc(3);
    reset_n = 1'b1;
    en = 1'b1;
    cyc(2);
    mon_en = 1'b1;
    // down from 0: saturates without WRAP, wraps to 7 with WRAP
    press(1'b0, 1'b1, DEB + 5);
    chk("sat_low_obj", int'(obj), 0);
    chk("sat_low_pend", int'(pend), 0);
    chk("wrap_low_obj", int'(obj_w), 7);
    // three ups with no period end: pending, core index untouched
    repeat (3) press(1'b1, 1'b0, DEB + 5);
    chk("t4_num_hold", int'(num), 0);
    chk("t4_pend", int'(pend), 1);
    period_end("t4");
    chk("t4_num", int'(num), 3);
    chk("t4_pend_clr", int'(pend), 0);
    // simultaneous buttons and disabled presses are discarded
    press(1'b1, 1'b1, DEB + 5);
    chk("simul_obj", int'(obj), 3);
    en = 1'b0;
    press(1'b1, 1'b0, DEB + 5);
    chk("dis_obj", int'(obj), 3);
    // disabling after a request does not cancel it
    en = 1'b1;
    press(1'b1, 1'b0, DEB + 5);
    en = 1'b0;
    period_end("dis_pend");
    chk("dis_pend_num", int'(num), 4);
    en = 1'b1;
    // debounce: too short a press is ignored, bouncy press counts once
    press(1'b1, 1'b0, DEB - 1);
    chk("deb_short_obj", int'(obj), 4);
    bounce_press();
    chk("deb_bounce_obj", int'(obj), 5);
    // saturate at 7
    repeat (9) press(1'b1, 1'b0, DEB + 5);
    chk("sat_high_obj", int'(obj), 7);
    period_end("sat_high");
    chk("sat_high_num", int'(num), 7);
    // cancel: down then up while pending returns to idle
    press(1'b0, 1'b1, DEB + 5);
    chk("cancel_pend_set", int'(pend), 1);
    press(1'b1, 1'b0, DEB + 5);
    chk("cancel_pend", int'(pend), 0);
    chk("cancel_num", int'(num), 7);
    period_end("cancel");
    // async reset in the middle of a pending change
    press(1'b0, 1'b1, DEB + 5);
    chk("t1_pend_set", int'(pend), 1);
    @(posedge clk); #1 mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t1_num", int'(num), 0);
    chk("t1_obj", int'(obj), 0);
    chk("t1_pend", int'(pend), 0);
    chk("t1_cok", int'(cok), 0);
    exp_obj_q.delete();
    exp_num_q.delete();
    m_obj = 0;
    m_num = 0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    mon_en = 1'b1;
    chk("t1_idle_pend", int'(pend), 0);
    period_end("t1_idle");
    chk("t1_idle_num", int'(num), 0);
    chk("sb_obj_empty", exp_obj_q.size(), 0);
    chk("sb_num_empty", exp_num_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
